// File: rtl/cross_corr_axil_master.sv
// AXI4-Lite initiator for the cross-correlation register port.
// Turns one command into one AXI-Lite transaction and returns one response.
module cross_corr_axil_master #(
  parameter int C_M00_AXI_ADDR_WIDTH = 5,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int timeout_g = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0] rsp_resp,
  output logic rsp_timeout,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_awaddr,
  output logic [2:0] m00_axi_awprot,
  output logic m00_axi_awvalid,
  input  logic m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic m00_axi_wvalid,
  input  logic m00_axi_wready,
  input  logic [1:0] m00_axi_bresp,
  input  logic m00_axi_bvalid,
  output logic m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [2:0] m00_axi_arprot,
  output logic m00_axi_arvalid,
  input  logic m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0] m00_axi_rresp,
  input  logic m00_axi_rvalid,
  output logic m00_axi_rready
);

  localparam int TW = (timeout_g < 256) ? 8 : $clog2(timeout_g + 1);

  typedef enum logic [2:0] {
    IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP
  } state_t;

  state_t state;
  logic [TW-1:0] timer;
  logic expire;
  logic aw_hs, w_hs, aw_done, w_done;

  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;

  assign expire = (timer == TW'(timeout_g - 1));
  assign aw_hs = m00_axi_awvalid && m00_axi_awready;
  assign w_hs = m00_axi_wvalid && m00_axi_wready;
  // a channel whose valid already dropped has completed its handshake
  assign aw_done = !m00_axi_awvalid || aw_hs;
  assign w_done = !m00_axi_wvalid || w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
      rsp_timeout <= 1'b0;
      m00_axi_awaddr <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata <= '0;
      m00_axi_wstrb <= '0;
      m00_axi_wvalid <= 1'b0;
      m00_axi_bready <= 1'b0;
      m00_axi_araddr <= '0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            timer <= '0;
            rsp_rdata <= '0;
            rsp_resp <= 2'b00;
            rsp_timeout <= 1'b0;
            if (cmd_write) begin
              m00_axi_awaddr <= cmd_addr;
              m00_axi_wdata <= cmd_wdata;
              m00_axi_wstrb <= cmd_wstrb;
              m00_axi_awvalid <= 1'b1;
              m00_axi_wvalid <= 1'b1;
              state <= WR_AW_W;
            end else begin
              m00_axi_araddr <= cmd_addr;
              m00_axi_arvalid <= 1'b1;
              state <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (aw_hs) m00_axi_awvalid <= 1'b0;
          if (w_hs) m00_axi_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            m00_axi_bready <= 1'b1;
            timer <= '0;
            state <= WR_B;
          end else if (aw_hs || w_hs) begin
            timer <= '0;
          end else if (expire) begin
            m00_axi_awvalid <= 1'b0;
            m00_axi_wvalid <= 1'b0;
            rsp_resp <= 2'b10;
            rsp_timeout <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WR_B: begin
          if (m00_axi_bvalid) begin
            rsp_resp <= m00_axi_bresp;
            rsp_rdata <= '0;
            m00_axi_bready <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RSP;
          end else if (expire) begin
            m00_axi_bready <= 1'b0;
            rsp_resp <= 2'b10;
            rsp_timeout <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RD_AR: begin
          if (m00_axi_arready) begin
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready <= 1'b1;
            timer <= '0;
            state <= RD_R;
          end else if (expire) begin
            m00_axi_arvalid <= 1'b0;
            rsp_resp <= 2'b10;
            rsp_timeout <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RD_R: begin
          if (m00_axi_rvalid) begin
            rsp_rdata <= m00_axi_rdata;
            rsp_resp <= m00_axi_rresp;
            m00_axi_rready <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RSP;
          end else if (expire) begin
            m00_axi_rready <= 1'b0;
            rsp_resp <= 2'b10;
            rsp_timeout <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RSP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cross_corr_axil_master.sv
// Directed plus random bench for cross_corr_axil_master.
// A bench-side slave memory serves AXI traffic; a word-array model predicts responses.
module tb_cross_corr_axil_master;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [4:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic rsp_timeout;
  logic [4:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic bvalid, bready, arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [8];
  logic [31:0] slave_mem [8];

  always #5 clk = ~clk;

  cross_corr_axil_master #(
    .C_M00_AXI_ADDR_WIDTH(5),
    .C_M00_AXI_DATA_WIDTH(32),
    .timeout_g(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid),
    .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00;
    rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(
    input logic wr, input logic [4:0] addr, input logic [31:0] data,
    input logic [3:0] strb, input int aw_dly, input int w_dly,
    input int ar_dly, input int rsp_dly, input logic [1:0] sresp,
    input int hold, input logic exp_to, input int exp_lat,
    input int exp_awv, input int exp_wv, input int exp_arv);
    int aw_w, w_w, ar_w, b_w, r_w;
    int n_aw, n_w, n_ar, n_b, n_r, n_awv, n_wv, n_arv, lat, guard;
    logic got_aw, got_w, b_pend, r_pend, seen;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [4:0] wa, ra;
    logic [31:0] wd, exp_rd;
    logic [3:0] ws;
    logic [1:0] exp_rs;
    aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
    n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0;
    n_awv = 0; n_wv = 0; n_arv = 0; lat = 0;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; seen = 0;
    wa = '0; ra = '0; wd = '0; ws = '0;
    // reference model: byte-strobed word registers
    exp_rd = 32'h0;
    if (wr) begin
      if (!exp_to)
        for (int b = 0; b < 4; b++)
          if (strb[b]) exp_mem[addr[4:2]][8*b +: 8] = data[8*b +: 8];
    end else if (!exp_to) begin
      exp_rd = exp_mem[addr[4:2]];
    end
    exp_rs = exp_to ? 2'b10 : sresp;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    guard = 0;
    while (!cmd_ready && guard < 20) begin tick(); guard++; end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;

    for (int c = 1; c <= 60 && !seen; c++) begin
      if (rsp_valid) begin
        seen = 1; lat = c;
      end else begin
        awready = awvalid && (aw_w >= aw_dly);
        wready = wvalid && (w_w >= w_dly);
        arready = arvalid && (ar_w >= ar_dly);
        bvalid = b_pend && (b_w >= rsp_dly);
        bresp = sresp;
        rvalid = r_pend && (r_w >= rsp_dly);
        rresp = sresp;
        rdata = slave_mem[ra[4:2]];
        if (awvalid) begin
          n_awv++;
          if (awaddr !== addr) chk("awaddr", 32'(awaddr), 32'(addr));
        end
        if (wvalid) begin
          n_wv++;
          if (wdata !== data) chk("wdata", wdata, data);
        end
        if (arvalid) begin
          n_arv++;
          if (araddr !== addr) chk("araddr", 32'(araddr), 32'(addr));
        end
        aw_hs = awvalid && awready;
        w_hs = wvalid && wready;
        ar_hs = arvalid && arready;
        b_hs = bvalid && bready;
        r_hs = rvalid && rready;
        if (awvalid && !aw_hs) aw_w++;
        if (wvalid && !w_hs) w_w++;
        if (arvalid && !ar_hs) ar_w++;
        if (b_pend && !b_hs) b_w++;
        if (r_pend && !r_hs) r_w++;
        if (aw_hs) begin n_aw++; got_aw = 1; wa = awaddr; end
        if (w_hs) begin n_w++; got_w = 1; wd = wdata; ws = wstrb; end
        if (ar_hs) begin n_ar++; ra = araddr; end
        tick();
        slave_idle();
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) slave_mem[wa[4:2]][8*b +: 8] = wd[8*b +: 8];
          got_aw = 0; got_w = 0; b_pend = 1; b_w = 0;
        end
        if (b_hs) begin n_b++; b_pend = 0; end
        if (ar_hs) begin r_pend = 1; r_w = 0; end
        if (r_hs) begin n_r++; r_pend = 0; end
      end
    end

    chk("rsp_seen", 32'(seen), 32'd1);
    if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_resp", 32'(rsp_resp), 32'(exp_rs));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    if (exp_awv >= 0) chk("awvalid_cycles", 32'(n_awv), 32'(exp_awv));
    if (exp_wv >= 0) chk("wvalid_cycles", 32'(n_wv), 32'(exp_wv));
    if (exp_arv >= 0) chk("arvalid_cycles", 32'(n_arv), 32'(exp_arv));
    if (!exp_to) begin
      if (wr) begin
        chk("aw_handshakes", 32'(n_aw), 32'd1);
        chk("w_handshakes", 32'(n_w), 32'd1);
        chk("b_handshakes", 32'(n_b), 32'd1);
      end else begin
        chk("ar_handshakes", 32'(n_ar), 32'd1);
        chk("r_handshakes", 32'(n_r), 32'd1);
      end
    end

    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_resp", 32'(rsp_resp), 32'(exp_rs));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    chk("rsp_done_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic wr;
    logic [4:0] a;
    int ad, wd_, rd, hd;
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = 32'h0;
      slave_mem[i] = 32'h0;
    end
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    slave_idle();
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_prot", 32'({awprot, arprot}), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // zero-wait write, then read back
    run_cmd(1, 5'h00, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 2'b00, 0, 0, 3, 1, 1, 0);
    run_cmd(0, 5'h00, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0, 0, 3, 0, 0, 1);
    // read with arready delayed 4 cycles
    run_cmd(1, 5'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 0, 0, 3, 1, 1, 0);
    run_cmd(0, 5'h04, 32'h0, 4'h0, 0, 0, 4, 0, 2'b00, 0, 0, 7, 0, 0, 5);
    // wready three cycles ahead of awready
    run_cmd(1, 5'h0C, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 2'b00, 0, 0, 6, 4, 1, 0);
    // arready never comes: timeout after 16 waiting cycles
    run_cmd(0, 5'h10, 32'h0, 4'h0, 0, 0, 1000, 0, 2'b00, 0, 1, 17, 0, 0, 16);
    run_cmd(0, 5'h0C, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0, 0, 3, 0, 0, 1);
    // SLVERR response held 10 cycles
    run_cmd(1, 5'h14, 32'hA5A5_0F0F, 4'h5, 0, 0, 0, 1, 2'b10, 10, 0, 4, 1, 1, 0);

    // stray slave signals while idle are ignored
    bvalid = 1'b1; rvalid = 1'b1; awready = 1'b1; arready = 1'b1;
    repeat (3) begin
      tick();
      chk("stray_bready", 32'(bready), 32'd0);
      chk("stray_rready", 32'(rready), 32'd0);
      chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stray_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    slave_idle();

    // reset while waiting for B
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h08;
    cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    tick();
    slave_idle();
    chk("wrb_bready", 32'(bready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("async_rst_bready", 32'(bready), 32'd0);
    chk("async_rst_awvalid", 32'(awvalid), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    run_cmd(1, 5'h08, 32'h0BAD_CAFE, 4'hF, 0, 0, 0, 0, 2'b00, 0, 0, 3, 1, 1, 0);
    run_cmd(0, 5'h08, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0, 0, 3, 0, 0, 1);

    // randomized traffic against the word-array model
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = {3'($urandom_range(0, 7)), 2'b00};
      ad = $urandom_range(0, 3);
      wd_ = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      hd = $urandom_range(0, 2);
      if (wr)
        run_cmd(1, a, $urandom, 4'($urandom_range(0, 15)), ad, wd_, 0, rd,
                ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, hd, 0,
                3 + ((ad > wd_) ? ad : wd_) + rd, ad + 1, wd_ + 1, 0);
      else
        run_cmd(0, a, 32'h0, 4'h0, 0, 0, ad, rd,
                ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, hd, 0,
                3 + ad + rd, 0, 0, ad + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
